// File: rtl/fx_narrow_sat.sv
// Two-stage signed fixed-point narrowing: drop LSBs (round-half-up or floor), then drop MSBs
// (saturate or wrap), flagging overflow per sample and counting overflows in a sticky counter.
module fx_narrow_sat #(
    parameter int IN_W     = 14,
    parameter int IN_FRAC  = 6,
    parameter int OUT_W    = 10,
    parameter int OUT_FRAC = 4,
    parameter int ROUND    = 1,
    parameter int SAT      = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [IN_W-1:0]  i_data,
    input  logic             i_clr,
    output logic             o_valid,
    output logic [OUT_W-1:0] o_data,
    output logic             o_ovf,
    output logic [CNT_W-1:0] o_ovf_cnt
);

    localparam int D   = IN_FRAC - OUT_FRAC;
    localparam int DS  = (D > 0) ? D : 0;
    localparam int Q_W = IN_W - DS + 1;
    localparam int RB  = (DS > 0) ? DS - 1 : 0;

    generate
        if (D < 0) begin : g_err_frac
            $error("fx_narrow_sat: OUT_FRAC must not exceed IN_FRAC");
        end
        if (OUT_W > IN_W - D + 1) begin : g_err_width
            $error("fx_narrow_sat: OUT_W exceeds the quantized word width");
        end
        if (ROUND != 0 && D == 0) begin : g_warn_round
            $warning("fx_narrow_sat: ROUND has no effect when no LSBs are dropped");
        end
    endgenerate

    // One guard bit above the shifted input keeps the +1 rounding increment from wrapping.
    function automatic logic signed [Q_W-1:0] quantize(input logic signed [IN_W-1:0] x);
        logic signed [IN_W:0] wide;
        logic                 rnd;
        wide = {x[IN_W-1], x};
        wide = wide >>> DS;
        rnd  = (ROUND != 0 && D > 0) ? x[RB] : 1'b0;
        wide = wide + $signed({{IN_W{1'b0}}, rnd});
        return wide[Q_W-1:0];
    endfunction

    // Returns {overflow, narrowed word}; fits when everything above OUT_W-1 is pure sign.
    function automatic logic [OUT_W:0] narrow(input logic signed [Q_W-1:0] q);
        logic signed [Q_W-1:0] hi;
        logic [OUT_W-1:0]      r;
        logic                  ovf;
        hi  = q >>> (OUT_W - 1);
        ovf = (hi != '0) && (hi != '1);
        if (ovf && SAT != 0) begin
            r = q[Q_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end else begin
            r = q[OUT_W-1:0];
        end
        return {ovf, r};
    endfunction

    logic                    vld_p1_q, vld_p1_d;
    logic signed [Q_W-1:0]   quant_p1_q, quant_p1_d;
    logic [OUT_W:0]          narrow_p1;
    logic                    vld_p2_q, vld_p2_d;
    logic signed [OUT_W-1:0] data_p2_q, data_p2_d;
    logic                    ovf_p2_q, ovf_p2_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    always_comb begin
        // stage 1: quantize LSBs
        vld_p1_d   = i_valid;
        quant_p1_d = i_valid ? quantize(i_data) : quant_p1_q;

        // stage 2: range reduction, overflow flag and counter
        narrow_p1 = narrow(quant_p1_q);
        vld_p2_d  = vld_p1_q;
        data_p2_d = vld_p1_q ? narrow_p1[OUT_W-1:0] : data_p2_q;
        ovf_p2_d  = vld_p1_q ? narrow_p1[OUT_W] : ovf_p2_q;

        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (vld_p1_q && narrow_p1[OUT_W] && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q   <= 1'b0;
            quant_p1_q <= '0;
            vld_p2_q   <= 1'b0;
            data_p2_q  <= '0;
            ovf_p2_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            vld_p1_q   <= vld_p1_d;
            quant_p1_q <= quant_p1_d;
            vld_p2_q   <= vld_p2_d;
            data_p2_q  <= data_p2_d;
            ovf_p2_q   <= ovf_p2_d;
            cnt_q      <= cnt_d;
        end
    end

    assign o_valid   = vld_p2_q;
    assign o_data    = data_p2_q;
    assign o_ovf     = ovf_p2_q;
    assign o_ovf_cnt = cnt_q;

endmodule

// File: tb/tb_fx_narrow_sat.sv
// Directed bench for fx_narrow_sat: default, truncating, wrapping and 2-bit-counter
// instances share one input stream and are checked against hand-computed values.
module tb_fx_narrow_sat;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic [13:0] i_data;
    logic        i_clr;

    logic        def_valid, trn_valid, wrp_valid, c2_valid;
    logic [9:0]  def_data, trn_data, wrp_data, c2_data;
    logic        def_ovf, trn_ovf, wrp_ovf, c2_ovf;
    logic [15:0] def_cnt, trn_cnt, wrp_cnt;
    logic [1:0]  c2_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fx_narrow_sat u_def (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data), .i_clr(i_clr),
        .o_valid(def_valid), .o_data(def_data), .o_ovf(def_ovf), .o_ovf_cnt(def_cnt)
    );

    fx_narrow_sat #(.ROUND(0)) u_trn (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data), .i_clr(i_clr),
        .o_valid(trn_valid), .o_data(trn_data), .o_ovf(trn_ovf), .o_ovf_cnt(trn_cnt)
    );

    fx_narrow_sat #(.SAT(0)) u_wrp (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data), .i_clr(i_clr),
        .o_valid(wrp_valid), .o_data(wrp_data), .o_ovf(wrp_ovf), .o_ovf_cnt(wrp_cnt)
    );

    fx_narrow_sat #(.CNT_W(2)) u_c2 (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data), .i_clr(i_clr),
        .o_valid(c2_valid), .o_data(c2_data), .o_ovf(c2_ovf), .o_ovf_cnt(c2_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Present one sample, confirm nothing emerges after one edge, stop at the output edge.
    task automatic xfer(input logic [13:0] d);
        i_valid = 1'b1;
        i_data  = d;
        tick();
        i_valid = 1'b0;
        chk("latency_early", 32'(def_valid), 32'd0);
        tick();
        chk("latency_out", 32'(def_valid), 32'd1);
    endtask

    // Round half up is floor((v+2)/4); then clamp to the signed 10-bit range.
    function automatic logic [10:0] ref_def(input logic [13:0] d);
        int         v;
        int         q;
        logic       ovf;
        logic [9:0] r;
        v = int'($signed(d));
        q = (v + 2) >>> 2;
        ovf = 1'b0;
        if (q > 511) begin
            r = 10'h1FF;
            ovf = 1'b1;
        end else if (q < -512) begin
            r = 10'h200;
            ovf = 1'b1;
        end else begin
            r = q[9:0];
        end
        return {ovf, r};
    endfunction

    logic [10:0] exp_q[$];
    logic [10:0] last;
    logic        prev_v;
    logic        cur_v;
    logic [13:0] d;

    initial begin
        rst     = 1'b1;
        i_valid = 1'b0;
        i_data  = '0;
        i_clr   = 1'b0;
        tick();
        tick();
        chk("rst_valid", 32'(def_valid), 32'd0);
        chk("rst_data",  32'(def_data),  32'd0);
        chk("rst_ovf",   32'(def_ovf),   32'd0);
        chk("rst_cnt",   32'(def_cnt),   32'd0);
        rst = 1'b0;
        tick();

        // rounding and truncation
        xfer(14'd5);
        chk("rnd5_data", 32'(def_data), 32'h001);
        chk("rnd5_ovf",  32'(def_ovf),  32'd0);
        chk("trn5_data", 32'(trn_data), 32'h001);
        xfer(14'd6);
        chk("rnd6_data", 32'(def_data), 32'h002);
        chk("rnd6_ovf",  32'(def_ovf),  32'd0);
        chk("trn6_data", 32'(trn_data), 32'h001);
        xfer(14'h3FFA);
        chk("rndm6_data", 32'(def_data), 32'h3FF);
        chk("rndm6_ovf",  32'(def_ovf),  32'd0);
        chk("trnm6_data", 32'(trn_data), 32'h3FE);
        chk("trnm6_ovf",  32'(trn_ovf),  32'd0);

        // saturation, wrap, counter
        xfer(14'h1FFF);
        chk("sat_pos_data", 32'(def_data), 32'h1FF);
        chk("sat_pos_ovf",  32'(def_ovf),  32'd1);
        chk("wrp_pos_data", 32'(wrp_data), 32'h000);
        chk("wrp_pos_ovf",  32'(wrp_ovf),  32'd1);
        chk("cnt_1",        32'(def_cnt),  32'd1);
        xfer(14'h2000);
        chk("sat_neg_data", 32'(def_data), 32'h200);
        chk("sat_neg_ovf",  32'(def_ovf),  32'd1);
        chk("wrp_neg_data", 32'(wrp_data), 32'h000);
        chk("wrp_neg_ovf",  32'(wrp_ovf),  32'd1);
        chk("cnt_2",        32'(def_cnt),  32'd2);
        xfer(14'd2046);
        chk("sat_rnd_data", 32'(def_data), 32'h1FF);
        chk("sat_rnd_ovf",  32'(def_ovf),  32'd1);
        chk("wrp_rnd_data", 32'(wrp_data), 32'h200);
        chk("trn_2046_ovf", 32'(trn_ovf),  32'd0);
        chk("cnt_3",        32'(def_cnt),  32'd3);
        chk("trn_cnt_2",    32'(trn_cnt),  32'd2);
        xfer(14'd2045);
        chk("fit_2045_data", 32'(def_data), 32'h1FF);
        chk("fit_2045_ovf",  32'(def_ovf),  32'd0);
        chk("cnt_hold_3",    32'(def_cnt),  32'd3);

        // clear coinciding with a fourth overflow wins
        i_valid = 1'b1;
        i_data  = 14'h1FFF;
        tick();
        i_valid = 1'b0;
        i_clr   = 1'b1;
        tick();
        i_clr = 1'b0;
        chk("clr_valid", 32'(def_valid), 32'd1);
        chk("clr_ovf",   32'(def_ovf),   32'd1);
        chk("clr_cnt",   32'(def_cnt),   32'd0);
        chk("clr_c2cnt", 32'(c2_cnt),    32'd0);

        // back-to-back overflow burst; 2-bit counter holds at 3
        for (int k = 0; k < 5; k++) begin
            i_valid = 1'b1;
            i_data  = 14'h1FFF;
            tick();
            if (k >= 1) chk("burst_valid", 32'(def_valid), 32'd1);
        end
        i_valid = 1'b0;
        tick();
        chk("burst_last_valid", 32'(def_valid), 32'd1);
        chk("burst_cnt5",       32'(def_cnt),   32'd5);
        chk("burst_c2_held",    32'(c2_cnt),    32'd3);
        tick();
        chk("burst_end_valid",  32'(def_valid), 32'd0);
        chk("burst_hold_data",  32'(def_data),  32'h1FF);

        // alternating valid with random data; outputs in order, held across bubbles
        prev_v = 1'b0;
        last   = {1'b1, 10'h1FF};
        for (int c = 0; c < 42; c++) begin
            if (c < 40 && (c % 2) == 0) begin
                d = 14'($urandom);
                i_valid = 1'b1;
                i_data  = d;
                exp_q.push_back(ref_def(d));
                cur_v = 1'b1;
            end else begin
                i_valid = 1'b0;
                cur_v   = 1'b0;
            end
            tick();
            chk("strm_valid", 32'(def_valid), 32'(prev_v));
            if (prev_v) last = exp_q.pop_front();
            chk("strm_data", 32'(def_data), 32'(last[9:0]));
            chk("strm_ovf",  32'(def_ovf),  32'(last[10]));
            prev_v = cur_v;
        end

        // reset with samples in flight
        i_valid = 1'b1;
        i_data  = 14'h1FFF;
        tick();
        i_data = 14'd5;
        rst    = 1'b1;
        tick();
        rst     = 1'b0;
        i_valid = 1'b0;
        chk("mrst_valid", 32'(def_valid), 32'd0);
        chk("mrst_data",  32'(def_data),  32'd0);
        chk("mrst_ovf",   32'(def_ovf),   32'd0);
        chk("mrst_cnt",   32'(def_cnt),   32'd0);
        chk("mrst_c2cnt", 32'(c2_cnt),    32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("mrst_no_stale", 32'(def_valid), 32'd0);
        end
        xfer(14'd6);
        chk("post_rst_data", 32'(def_data), 32'h002);
        chk("post_rst_ovf",  32'(def_ovf),  32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
